// File: rtl/output_buffer_tx_pkg.sv
// rtl/output_buffer_tx_pkg.sv - flit type codes, FSM states and helpers shared by the output buffer
package output_buffer_tx_pkg;

    localparam int FLIT_TYPE_BITS = 2;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // A flit that closes a packet bumps the delivered-packet counter.
    function automatic logic is_pkt_end(input logic [1:0] flit_type);
        return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/output_buffer_tx_if.sv
// rtl/output_buffer_tx_if.sv - crossbar-side push and downstream-side transmit signal bundle
// Signals: in_din/in_wr_en/in_ack (crossbar push), tx_dout/tx_wr_en/tx_ack (to next hop).
// master: crossbar + downstream environment; slave: output_buffer_tx.
interface output_buffer_tx_if #(
    parameter int DATA_WIDTH = 70
);
    logic [DATA_WIDTH-1:0] in_din;
    logic                  in_wr_en;
    logic                  in_ack;
    logic [DATA_WIDTH-1:0] tx_dout;
    logic                  tx_wr_en;
    logic                  tx_ack;

    modport master (
        output in_din, in_wr_en, tx_ack,
        input  in_ack, tx_dout, tx_wr_en
    );

    modport slave (
        input  in_din, in_wr_en, tx_ack,
        output in_ack, tx_dout, tx_wr_en
    );
endinterface

// File: rtl/output_buffer_tx_fifo.sv
// rtl/output_buffer_tx_fifo.sv - tx_flit_fifo: local flit storage with wrapping pointers and occupancy count
// Ports: clk, rst_n, wr_data/wr_en (push), rd_en (pop), rd_data (head, show-ahead), full, empty.
// A push while full and a pop while empty are ignored; push and pop together keep the count.
module tx_flit_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/output_buffer_tx.sv
// rtl/output_buffer_tx.sv - router output-port transmitter with whole-packet framing
// Ports: clk, rst_n, bus (output_buffer_tx_if.slave: crossbar push + downstream transmit),
//        busy (mid-packet), pkt_cnt (packets delivered), fmt_err (sticky stray flit),
//        stall_err (sticky watchdog, only with TX_WATCHDOG_EN defined, else 0).
module output_buffer_tx
    import output_buffer_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_WIDTH  = 4,
    parameter int DATA_WIDTH  = 70,
    parameter int STALL_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output_buffer_tx_if.slave     bus,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic                  fmt_err,
    output logic                  stall_err
);
    localparam int FLIT_TYPE_MSB = DATA_WIDTH - 1;
    localparam int FLIT_TYPE_LSB = DATA_WIDTH - FLIT_TYPE_BITS;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [1:0]            head_type;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_free;
    logic                  load;
    logic                  discard;
    tx_state_e             state;
    tx_state_e             state_nxt;

    assign bus.in_ack   = bus.in_wr_en && !fifo_full;
    assign bus.tx_dout  = out_data;
    assign bus.tx_wr_en = out_valid;
    assign busy         = (state == ST_SEND);
    assign head_type    = fifo_head[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
    // The output slot can take a new flit if empty or being consumed this cycle.
    assign out_free     = !out_valid || bus.tx_ack;

    tx_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (FIFO_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (bus.in_din),
        .wr_en   (bus.in_wr_en),
        .rd_en   (load || discard),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Outside a packet only HEAD/SINGLE may start transmission; a stray BODY/TAIL
    // is dropped without waiting for the output slot so it cannot block the queue.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        discard   = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                if (head_type == FLIT_BODY || head_type == FLIT_TAIL) begin
                    discard = 1'b1;
                end else if (out_free) begin
                    load = 1'b1;
                    if (head_type == FLIT_HEAD) state_nxt = ST_SEND;
                end
            end else if (out_free) begin
                load = 1'b1;
                if (head_type == FLIT_TAIL) state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            pkt_cnt   <= '0;
            fmt_err   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= fifo_head;
                out_valid <= 1'b1;
            end else if (bus.tx_ack) begin
                out_valid <= 1'b0;
            end
            if (out_valid && bus.tx_ack && is_pkt_end(out_data[FLIT_TYPE_MSB:FLIT_TYPE_LSB]))
                pkt_cnt <= pkt_cnt + 16'd1;
            if (discard) fmt_err <= 1'b1;
        end
    end

`ifdef TX_WATCHDOG_EN
    localparam int WD_W = (STALL_LIMIT > 255) ? $clog2(STALL_LIMIT + 1) : 8;

    logic [WD_W-1:0] wd_cnt;
    logic            stall_flag;

    // Counts consecutive cycles a presented flit is refused; the flag is raised on
    // the edge the count reaches STALL_LIMIT and holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt     <= '0;
            stall_flag <= 1'b0;
        end else if (out_valid && !bus.tx_ack) begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt >= WD_W'(STALL_LIMIT - 1)) stall_flag <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign stall_err = stall_flag;
`else
    logic unused_stall_limit;
    assign unused_stall_limit = (STALL_LIMIT == 0);
    assign stall_err          = 1'b0;
`endif
endmodule

// File: tb/tb_output_buffer_tx.sv
// tb/tb_output_buffer_tx.sv - self-checking bench for output_buffer_tx (vector table, corner sequences, random vs model)
module tb_output_buffer_tx;
    import output_buffer_tx_pkg::*;

    localparam int DW = 70;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        fmt_err;
    logic        stall_err;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    output_buffer_tx_if #(.DATA_WIDTH(DW)) bus ();

    output_buffer_tx #(
        .FIFO_DEPTH  (16),
        .FIFO_WIDTH  (4),
        .DATA_WIDTH  (DW),
        .STALL_LIMIT (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .fmt_err   (fmt_err),
        .stall_err (stall_err)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  typ;
        logic [7:0]  tag;
        logic        ack;
        logic        e_in_ack;
        logic        e_vld;
        logic [1:0]  e_typ;
        logic [7:0]  e_tag;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    vec_t            vq[$];
    logic [DW-1:0]   seen[$];
    logic [DW-1:0]   pend[$];
    logic [DW-1:0]   m_fifo[$];
    logic            m_vld;
    logic [DW-1:0]   m_out;
    logic            m_pkt;
    logic [15:0]     m_cnt;
    logic            m_fmt;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [7:0] tag);
        return {t, 60'd0, tag};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [DW-1:0] din, input logic ack);
        bus.in_wr_en = wr;
        bus.in_din   = din;
        bus.tx_ack   = ack;
    endtask

    task automatic drain_collect(input int cycles);
        seen.delete();
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < cycles; i++) begin
            if (bus.tx_wr_en) seen.push_back(bus.tx_dout);
            tick();
        end
        bus.tx_ack = 1'b0;
    endtask

    task automatic gen_packet();
        int r;
        int k;
        r = $urandom_range(7);
        if (r == 0) begin
            pend.push_back({FLIT_BODY, 32'($urandom), 32'($urandom), 4'($urandom)});
        end else if (r <= 2) begin
            pend.push_back({FLIT_SINGLE, 32'($urandom), 32'($urandom), 4'($urandom)});
        end else begin
            pend.push_back({FLIT_HEAD, 32'($urandom), 32'($urandom), 4'($urandom)});
            k = $urandom_range(3);
            for (int j = 0; j < k; j++)
                pend.push_back({FLIT_BODY, 32'($urandom), 32'($urandom), 4'($urandom)});
            pend.push_back({FLIT_TAIL, 32'($urandom), 32'($urandom), 4'($urandom)});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_wr_en", DW'(bus.tx_wr_en), DW'(0));
        chk("rst_tx_dout",  bus.tx_dout,      DW'(0));
        chk("rst_in_ack",   DW'(bus.in_ack),   DW'(0));
        chk("rst_busy",     DW'(busy),         DW'(0));
        chk("rst_pkt_cnt",  DW'(pkt_cnt),      DW'(0));
        chk("rst_fmt_err",  DW'(fmt_err),      DW'(0));
        chk("rst_stall",    DW'(stall_err),    DW'(0));
        rst_n = 1'b1;

        // SINGLE with immediate ack, then a 4-flit packet held off for 5 cycles.
        vq.push_back('{1'b1, FLIT_SINGLE, 8'hAA, 1'b1, 1'b1, 1'b0, FLIT_BODY,   8'h00, 1'b0, 16'd0});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b1, FLIT_SINGLE, 8'hAA, 1'b0, 16'd0});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b0, FLIT_BODY,   8'h00, 1'b0, 16'd1});
        vq.push_back('{1'b1, FLIT_HEAD,   8'h01, 1'b0, 1'b1, 1'b0, FLIT_BODY,   8'h00, 1'b0, 16'd1});
        vq.push_back('{1'b1, FLIT_BODY,   8'h02, 1'b0, 1'b1, 1'b1, FLIT_HEAD,   8'h01, 1'b1, 16'd1});
        vq.push_back('{1'b1, FLIT_BODY,   8'h03, 1'b0, 1'b1, 1'b1, FLIT_HEAD,   8'h01, 1'b1, 16'd1});
        vq.push_back('{1'b1, FLIT_TAIL,   8'h04, 1'b0, 1'b1, 1'b1, FLIT_HEAD,   8'h01, 1'b1, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b0, 1'b0, 1'b1, FLIT_HEAD,   8'h01, 1'b1, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b0, 1'b0, 1'b1, FLIT_HEAD,   8'h01, 1'b1, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b1, FLIT_BODY,   8'h02, 1'b1, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b1, FLIT_BODY,   8'h03, 1'b1, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b1, FLIT_TAIL,   8'h04, 1'b0, 16'd1});
        vq.push_back('{1'b0, FLIT_BODY,   8'h00, 1'b1, 1'b0, 1'b0, FLIT_BODY,   8'h00, 1'b0, 16'd2});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wr, mk(vq[i].typ, vq[i].tag), vq[i].ack);
            #1;
            chk($sformatf("vec%0d_in_ack", i), DW'(bus.in_ack), DW'(vq[i].e_in_ack));
            tick();
            chk($sformatf("vec%0d_tx_wr_en", i), DW'(bus.tx_wr_en), DW'(vq[i].e_vld));
            if (vq[i].e_vld)
                chk($sformatf("vec%0d_tx_dout", i), bus.tx_dout, mk(vq[i].e_typ, vq[i].e_tag));
            chk($sformatf("vec%0d_busy", i), DW'(busy), DW'(vq[i].e_busy));
            chk($sformatf("vec%0d_pkt_cnt", i), DW'(pkt_cnt), DW'(vq[i].e_cnt));
        end

        // Watchdog: one presented flit refused continuously.
        drive(1'b1, mk(FLIT_SINGLE, 8'h50), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk("wd_tx_wr_en", DW'(bus.tx_wr_en), DW'(1));
`ifdef TX_WATCHDOG_EN
        repeat (9) tick();
        chk("wd_stall_before_limit", DW'(stall_err), DW'(0));
        tick();
        chk("wd_stall_at_limit", DW'(stall_err), DW'(1));
`else
        repeat (20) tick();
        chk("wd_stall_disabled", DW'(stall_err), DW'(0));
`endif
        drain_collect(4);
        chk("wd_seen_n", DW'(seen.size()), DW'(1));
        if (seen.size() > 0) chk("wd_seen0", seen[0], mk(FLIT_SINGLE, 8'h50));
        chk("wd_pkt_cnt", DW'(pkt_cnt), DW'(3));

        // Fill: HEAD sits in the output register, 16 more fill the FIFO, the next is refused.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, mk((i == 0) ? FLIT_HEAD : FLIT_BODY, 8'(8'h10 + i)), 1'b0);
            #1;
            chk($sformatf("fill%0d_in_ack", i), DW'(bus.in_ack), DW'(i < 17));
            tick();
        end
        chk("fill_hold_dout", bus.tx_dout, mk(FLIT_HEAD, 8'h10));
        drive(1'b1, mk(FLIT_TAIL, 8'h30), 1'b1);
        #1;
        chk("fill_full_pop_in_ack", DW'(bus.in_ack), DW'(0));
        tick();
        chk("fill_after_pop_dout", bus.tx_dout, mk(FLIT_BODY, 8'h11));
        drive(1'b1, mk(FLIT_TAIL, 8'h30), 1'b1);
        #1;
        chk("fill_push_pop_in_ack", DW'(bus.in_ack), DW'(1));
        tick();
        chk("fill_push_pop_dout", bus.tx_dout, mk(FLIT_BODY, 8'h12));
        drain_collect(25);
        chk("fill_seen_n", DW'(seen.size()), DW'(16));
        for (int i = 0; i < seen.size() && i < 16; i++)
            chk($sformatf("fill_seen%0d", i), seen[i],
                (i < 15) ? mk(FLIT_BODY, 8'(8'h12 + i)) : mk(FLIT_TAIL, 8'h30));
        chk("fill_busy", DW'(busy), DW'(0));
        chk("fill_pkt_cnt", DW'(pkt_cnt), DW'(4));

        // Stray BODY while idle is dropped, the following packet goes out.
        drive(1'b1, mk(FLIT_BODY, 8'h40), 1'b0);
        tick();
        drive(1'b1, mk(FLIT_HEAD, 8'h41), 1'b0);
        tick();
        drive(1'b1, mk(FLIT_TAIL, 8'h42), 1'b0);
        tick();
        drain_collect(8);
        chk("fmt_seen_n", DW'(seen.size()), DW'(2));
        if (seen.size() > 1) begin
            chk("fmt_seen0", seen[0], mk(FLIT_HEAD, 8'h41));
            chk("fmt_seen1", seen[1], mk(FLIT_TAIL, 8'h42));
        end
        chk("fmt_err", DW'(fmt_err), DW'(1));
        chk("fmt_pkt_cnt", DW'(pkt_cnt), DW'(5));

        // Asynchronous reset mid-packet after two flits delivered.
        drive(1'b1, mk(FLIT_HEAD, 8'h60), 1'b1);
        tick();
        drive(1'b1, mk(FLIT_BODY, 8'h61), 1'b1);
        tick();
        drive(1'b1, mk(FLIT_BODY, 8'h62), 1'b1);
        tick();
        drive(1'b1, mk(FLIT_TAIL, 8'h63), 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        chk("mid_tx_dout", bus.tx_dout, mk(FLIT_BODY, 8'h62));
        chk("mid_busy", DW'(busy), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_tx_wr_en", DW'(bus.tx_wr_en), DW'(0));
        chk("arst_busy", DW'(busy), DW'(0));
        chk("arst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        chk("arst_fmt_err", DW'(fmt_err), DW'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("post_rst%0d_tx_wr_en", i), DW'(bus.tx_wr_en), DW'(0));
            tick();
        end

        // Random traffic against a queue-based model of the framing rules.
        m_fifo.delete();
        m_vld = 1'b0;
        m_out = '0;
        m_pkt = 1'b0;
        m_cnt = '0;
        m_fmt = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic wr;
            logic ack;
            logic exp_ack;
            logic [1:0] t;
            logic [DW-1:0] din;
            if (pend.size() < 4) gen_packet();
            wr  = (pend.size() > 0) && ($urandom_range(9) < 7);
            ack = ($urandom_range(9) < 6);
            din = (pend.size() > 0) ? pend[0] : '0;
            drive(wr, din, ack);
            chk("rnd_tx_wr_en", DW'(bus.tx_wr_en), DW'(m_vld));
            if (m_vld) chk("rnd_tx_dout", bus.tx_dout, m_out);
            chk("rnd_busy", DW'(busy), DW'(m_pkt));
            chk("rnd_pkt_cnt", DW'(pkt_cnt), DW'(m_cnt));
            chk("rnd_fmt_err", DW'(fmt_err), DW'(m_fmt));
            exp_ack = wr && (m_fifo.size() < 16);
            #1;
            chk("rnd_in_ack", DW'(bus.in_ack), DW'(exp_ack));

            if (m_vld && ack) begin
                t = m_out[DW-1:DW-2];
                if (t == FLIT_TAIL || t == FLIT_SINGLE) m_cnt = m_cnt + 16'd1;
                m_vld = 1'b0;
            end
            if (m_fifo.size() > 0) begin
                t = m_fifo[0][DW-1:DW-2];
                if (!m_pkt && (t == FLIT_BODY || t == FLIT_TAIL)) begin
                    void'(m_fifo.pop_front());
                    m_fmt = 1'b1;
                end else if (!m_vld) begin
                    m_out = m_fifo.pop_front();
                    m_vld = 1'b1;
                    if (!m_pkt && t == FLIT_HEAD)    m_pkt = 1'b1;
                    else if (m_pkt && t == FLIT_TAIL) m_pkt = 1'b0;
                end
            end
            if (exp_ack) begin
                m_fifo.push_back(din);
                void'(pend.pop_front());
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
